// File: rtl/tl_sequence_monitor_pkg.sv
// Shared definitions for the traffic-light controller and its bus monitor:
// light codes, monitor state encoding and violation codes.
package tl_sequence_monitor_pkg;

    localparam logic [1:0] LightDark   = 2'b00;
    localparam logic [1:0] LightRed    = 2'b01;
    localparam logic [1:0] LightYellow = 2'b10;
    localparam logic [1:0] LightGreen  = 2'b11;

    typedef enum logic [2:0] {
        StDark  = 3'd0,
        StMrG   = 3'd1,
        StYMr   = 3'd2,
        StSrG   = 3'd3,
        StYSr   = 3'd4,
        StFault = 3'd5
    } mon_state_e;

    localparam logic [2:0] ErrNone        = 3'd0;
    localparam logic [2:0] ErrBothGreen   = 3'd1;
    localparam logic [2:0] ErrIllegalPair = 3'd2;
    localparam logic [2:0] ErrSequence    = 3'd3;
    localparam logic [2:0] ErrYellowLen   = 3'd4;
    localparam logic [2:0] ErrSrLen       = 3'd5;
    localparam logic [2:0] ErrMrShort     = 3'd6;

    function automatic logic pair_legal(input logic [1:0] mr, input logic [1:0] sr);
        return ({mr, sr} == {LightDark, LightDark})     ||
               ({mr, sr} == {LightGreen, LightRed})     ||
               ({mr, sr} == {LightYellow, LightYellow}) ||
               ({mr, sr} == {LightRed, LightGreen});
    endfunction

endpackage

// File: rtl/tl_sat_counter.sv
// 8-bit saturating counter; clear loads 1 and takes priority over increment.
module tl_sat_counter (
    input  logic       clk,
    input  logic       rst,
    input  logic       clr,
    input  logic       inc,
    output logic [7:0] count
);

    logic [7:0] count_q, count_d;

    always_comb begin
        count_d = count_q;
        if (clr) begin
            count_d = 8'd1;
        end else if (inc && (count_q != 8'hFF)) begin
            count_d = count_q + 8'd1;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            count_q <= 8'd0;
        end else begin
            count_q <= count_d;
        end
    end

    assign count = count_q;

endmodule

// File: rtl/tl_sequence_monitor.sv
// Passive light-bus checker: tracks the expected phase, measures phase runs and
// reports protocol/timing violations with a registered pulse, code and count.
module tl_sequence_monitor
    import tl_sequence_monitor_pkg::*;
#(
    parameter int unsigned MR_MIN_GREEN = 30,
    parameter int unsigned SR_GREEN_LEN = 10,
    parameter int unsigned YELLOW_LEN   = 3
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [1:0] MR_ctl,
    input  logic [1:0] SR_ctl,
    output logic       err_valid,
    output logic [2:0] err_code,
    output logic [7:0] err_count,
    output logic [7:0] sr_phases,
    output logic       fault
);

    mon_state_e  state_q, state_d;
    logic [3:0]  prev_q;
    logic        err_valid_q, fault_q;
    logic [2:0]  err_code_q;
    logic [7:0]  run;
    logic [31:0] run_ext;
    logic        pair_new, is_dark, is_mrg, is_yel, is_srg, both_green;
    logic        succ, err_d, sr_inc;
    logic [2:0]  code_d, len_code;

    assign pair_new   = {MR_ctl, SR_ctl} != prev_q;
    assign is_dark    = {MR_ctl, SR_ctl} == {LightDark, LightDark};
    assign is_mrg     = {MR_ctl, SR_ctl} == {LightGreen, LightRed};
    assign is_yel     = {MR_ctl, SR_ctl} == {LightYellow, LightYellow};
    assign is_srg     = {MR_ctl, SR_ctl} == {LightRed, LightGreen};
    assign both_green = {MR_ctl, SR_ctl} == {LightGreen, LightGreen};
    assign run_ext    = {24'd0, run};

    // Length of the phase that is ending, judged by the state it was tracked in.
    always_comb begin
        len_code = ErrNone;
        if (state_q == StMrG) begin
            if (run_ext < MR_MIN_GREEN) len_code = ErrMrShort;
        end else if ((state_q == StYMr) || (state_q == StYSr)) begin
            if (run_ext != YELLOW_LEN) len_code = ErrYellowLen;
        end else if (state_q == StSrG) begin
            if (run_ext != SR_GREEN_LEN) len_code = ErrSrLen;
        end
    end

    always_comb begin
        state_d = state_q;
        err_d   = 1'b0;
        code_d  = ErrNone;
        sr_inc  = 1'b0;
        succ    = (is_mrg && ((state_q == StDark) || (state_q == StYSr))) ||
                  (is_yel && ((state_q == StMrG) || (state_q == StSrG)))  ||
                  (is_srg && (state_q == StYMr));
        if (pair_new) begin
            if (is_dark) begin
                state_d = StDark;
            end else if (both_green) begin
                state_d = StFault;
                err_d   = 1'b1;
                code_d  = ErrBothGreen;
            end else if (!pair_legal(MR_ctl, SR_ctl)) begin
                state_d = StFault;
                err_d   = 1'b1;
                code_d  = ErrIllegalPair;
            end else if (state_q != StFault) begin
                if (succ) begin
                    if (is_mrg) begin
                        state_d = StMrG;
                    end else if (is_srg) begin
                        state_d = StSrG;
                    end else begin
                        state_d = (state_q == StMrG) ? StYMr : StYSr;
                    end
                    err_d  = (len_code != ErrNone);
                    code_d = len_code;
                    sr_inc = (state_q == StSrG) && (run_ext == SR_GREEN_LEN);
                end else begin
                    // Resync onto a green; an unexpected yellow gives no anchor.
                    err_d  = 1'b1;
                    code_d = ErrSequence;
                    if (is_mrg) begin
                        state_d = StMrG;
                    end else if (is_srg) begin
                        state_d = StSrG;
                    end else begin
                        state_d = StFault;
                    end
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= StDark;
            prev_q      <= {LightDark, LightDark};
            err_valid_q <= 1'b0;
            err_code_q  <= ErrNone;
            fault_q     <= 1'b0;
        end else begin
            state_q     <= state_d;
            prev_q      <= {MR_ctl, SR_ctl};
            err_valid_q <= err_d;
            if (err_d) err_code_q <= code_d;
            fault_q     <= (state_d == StFault);
        end
    end

    tl_sat_counter u_run_cnt (
        .clk   (clk),
        .rst   (rst),
        .clr   (pair_new),
        .inc   (1'b1),
        .count (run)
    );

    tl_sat_counter u_err_cnt (
        .clk   (clk),
        .rst   (rst),
        .clr   (1'b0),
        .inc   (err_d),
        .count (err_count)
    );

    tl_sat_counter u_sr_cnt (
        .clk   (clk),
        .rst   (rst),
        .clr   (1'b0),
        .inc   (sr_inc),
        .count (sr_phases)
    );

    assign err_valid = err_valid_q;
    assign err_code  = err_code_q;
    assign fault     = fault_q;

endmodule

// File: doc/tl_sequence_monitor.md
Name: tl_sequence_monitor

Overview:
- Passive checker on the receiving end of the smart traffic-light controller's light bus. It samples MR_ctl/SR_ctl each cycle, tracks the expected light phase and measures phase lengths.
- Reports every protocol or timing violation (both green, illegal light pair, wrong phase order, wrong phase length) as an error pulse and code. Keeps a saturating error count.
- Sits beside the controller in the top level and in benches; it never drives the lights.

Parameters:
- MR_MIN_GREEN, 30, minimum legal main-road green run in cycles (1..255)
- SR_GREEN_LEN, 10, exact legal secondary-road green run in cycles (1..255)
- YELLOW_LEN, 3, exact legal yellow run in cycles (1..255)

Ports:
- clk  in  1  system clock, all logic on rising edge
- rst  in  1  asynchronous active-low reset
- MR_ctl  in  2  main-road light code: 00 dark, 01 red, 10 yellow, 11 green
- SR_ctl  in  2  secondary-road light code, same encoding
- err_valid  out  1  one-cycle pulse, a violation was detected
- err_code  out  3  code of the most recent violation, held until the next one
- err_count  out  8  total violations, saturates at 255
- sr_phases  out  8  completed legal SR green phases, saturates at 255
- fault  out  1  high while the monitor is in FAULT (lost sync)

Behaviour:
- Reset (rst low, asynchronous):
  - state DARK, run counter 0
  - err_valid 0, err_code 0, err_count 0, sr_phases 0, fault 0
- Legal pairs (MR,SR): (00,00) dark, (11,01) MR green, (10,10) yellow, (01,11) SR green. Any other pair is illegal.
- States and transitions on a sampled pair change:
  - DARK: (11,01) goes to MR_G.
  - MR_G: (10,10) goes to Y_MR.
  - Y_MR: (01,11) goes to SR_G.
  - SR_G: (10,10) goes to Y_SR.
  - Y_SR: (11,01) goes to MR_G.
  - FAULT: only (00,00) leaves, going to DARK.
- Any state seeing (00,00) goes to DARK with no error (the controller was reset).
- Run counter: cleared to 1 on the first cycle of a new pair. Otherwise it increments, saturating at 255.
- Checks, evaluated in the cycle the new pair is sampled. The length checks use the run value of the phase just ended.
  - code 1 BOTH_GREEN: MR=11 and SR=11.
  - code 2 ILLEGAL_PAIR: any other illegal pair. Next state FAULT.
  - code 3 SEQUENCE: a legal pair that is not the listed successor, dark excluded. Resync: MR green goes to MR_G, SR green goes to SR_G, yellow goes to FAULT.
  - code 4 YELLOW_LEN: a yellow run ending with run != YELLOW_LEN.
  - code 5 SR_LEN: an SR green run ending with run != SR_GREEN_LEN.
  - code 6 MR_SHORT: an MR green run ending with run < MR_MIN_GREEN. MR green of any length >= MR_MIN_GREEN is legal, covering restarted and extended green.
- A phase ending in dark is exempt from length checks.
- Both green is also an illegal pair: it reports code 1 and the next state is FAULT.
- Simultaneous violations in one sample: only the lowest code is reported, and err_count increments by 1.
- Latency: err_valid, err_code and err_count update on the clock edge after the offending sample. Registered outputs, 1-cycle latency.
- sr_phases increments, with the same latency, when SR_G exits to Y_SR with run == SR_GREEN_LEN.
- In FAULT, length and sequence checks are suppressed. Illegal pairs still report codes 1/2.
- fault equals (state == FAULT), registered.
- Inputs are treated as synchronous to clk; no synchroniser.

Decomposition:
- Shared package holds:
  - light code constants DARK/RED/YELLOW/GREEN (2-bit)
  - monitor state encoding (3-bit)
  - error code constants 0..6 (3-bit)
- The controller and the monitor both use the light constants.
- One sub-module: tl_sat_counter, an 8-bit saturating counter with clear-to-1 and increment enables. It is used for the run counter, err_count and sr_phases.

Test Plan:
- Nominal cycle: dark 1, MR green 30, yellow 3, SR green 10, yellow 3, MR green 30.
  - Required: err_valid never high.
  - Required: sr_phases = 1.
- Extended/restarted MR green of 60 and then 90 cycles before yellow.
  - Required: no error.
- MR green 29 cycles, then yellow.
  - Required: err_valid pulse one cycle after the yellow sample.
  - Required: err_code = 6, err_count = 1.
- SR green 11 cycles; separately, a yellow run of 2 cycles.
  - Required: err_code 5, then err_code 4.
  - Required: err_count = 2; sr_phases unchanged by the bad SR phase.
- Pair (11,11) injected mid MR green.
  - Required: err_code 1, fault = 1 next cycle.
  - Required: later (10,10) and (01,11) produce no further errors.
  - Required: (00,00) clears fault.
- Yellow followed directly by (11,01) after an MR green.
  - Required: err_code 3, resync to MR_G.
- 300 forced violations.
  - Required: err_count holds 255.
- rst low mid-phase.
  - Required: all outputs 0 immediately, without waiting for a clock.
